// File: rtl/mul_approx_pipe.sv
// Pipelined unsigned WIDTHxWIDTH multiplier with selectable approximation
// (exact / column-truncated / truncated+bias) and an error-statistics monitor.
// The product and the exact product are formed at the input. Both then travel
// together through LATENCY register stages. The error is taken at the output
// handshake, so each beat's statistics follow the mode it was captured with.
module mul_approx_pipe #(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 4,
    parameter int LATENCY    = 2,
    parameter int CNT_W      = 32,
    parameter int SUM_W      = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    input  logic               err_clr,
    output logic [2*WIDTH-1:0] wce,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   err_sum
);
    localparam int PW  = 2 * WIDTH;
    localparam int BSH = (TRUNC_COLS > 0) ? TRUNC_COLS - 1 : 0;
    localparam logic [PW-1:0] BIAS = (TRUNC_COLS > 0) ? (PW'(1) << BSH) : '0;

    typedef struct packed {
        logic [PW-1:0] p;   // delivered (possibly approximate) product
        logic [PW-1:0] e;   // exact product, kept only for the error monitor
    } beat_t;

    logic              stall;
    logic              acc;
    logic              hs;
    logic [LATENCY:1]  vld_pipe;
    beat_t             stg [1:LATENCY];
    beat_t             nb;
    logic [PW-1:0]     trunc;
    logic [PW-1:0]     d;
    logic [SUM_W:0]    sum_nxt;

    // The whole pipe freezes on output backpressure; no bubble squeezing
    assign stall     = vld_pipe[LATENCY] && !out_ready;
    assign in_ready  = !stall;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_pipe[LATENCY];
    assign out_p     = stg[LATENCY].p;
    assign hs        = out_valid && out_ready;

    // Sum of the partial products in the kept columns (i+j >= K) only
    always_comb begin
        trunc = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                if (i + j >= TRUNC_COLS)
                    trunc = trunc + (PW'(in_a[i] & in_b[j]) << (i + j));
    end

    // Form the beat: exact product plus the product chosen by the mode
    always_comb begin
        nb.e = PW'(in_a) * PW'(in_b);
        case (in_mode)
            2'b01:   nb.p = trunc;
            2'b10:   nb.p = trunc + BIAS;
            default: nb.p = nb.e;
        endcase
    end

    // Shift the valid bits and the beat data forward together when not stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int k = 1; k <= LATENCY; k++) stg[k] <= '0;
        end else if (!stall) begin
            vld_pipe[1] <= acc;
            if (acc) stg[1] <= nb;
            for (int k = 2; k <= LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                stg[k]      <= stg[k-1];
            end
        end
    end

    // Absolute error of the beat at the output; bias can push P above E
    always_comb begin
        d = (stg[LATENCY].e >= stg[LATENCY].p) ? stg[LATENCY].e - stg[LATENCY].p
                                               : stg[LATENCY].p - stg[LATENCY].e;
        sum_nxt = {1'b0, err_sum} + (SUM_W+1)'(d);
    end

    // Error statistics; a clear takes priority over a coincident handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wce     <= '0;
            err_cnt <= '0;
            err_sum <= '0;
        end else if (err_clr) begin
            wce     <= '0;
            err_cnt <= '0;
            err_sum <= '0;
        end else if (hs) begin
            if (d > wce) wce <= d;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            err_sum <= sum_nxt[SUM_W] ? '1 : sum_nxt[SUM_W-1:0];
        end
    end
endmodule

// File: tb/tb_mul_approx_pipe.sv
// Bench for mul_approx_pipe: directed scenarios plus a randomized stream.
// Each beat is compared against a reference built from bitwise column sums,
// and the error statistics are checked against a running model.
module tb_mul_approx_pipe;
    localparam int W   = 8;
    localparam int K   = 4;
    localparam int LAT = 2;
    localparam int CW  = 32;
    localparam int SW  = 40;
    localparam int PW  = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, err_clr;
    logic [W-1:0]  in_a, in_b;
    logic [1:0]    in_mode;
    logic [PW-1:0] out_p, wce;
    logic [CW-1:0] err_cnt;
    logic [SW-1:0] err_sum;

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] q_p [$];
    logic [PW-1:0] q_d [$];
    logic [PW-1:0] m_wce;
    logic [CW-1:0] m_cnt;
    logic [SW-1:0] m_sum;

    always #5 clk = ~clk;

    mul_approx_pipe #(.WIDTH(W), .TRUNC_COLS(K), .LATENCY(LAT), .CNT_W(CW), .SUM_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .err_clr(err_clr), .wce(wce),
        .err_cnt(err_cnt), .err_sum(err_sum)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference product straight from the column rule
    function automatic int ref_p(input int a, input int b, input int m);
        int e;
        int t;
        e = a * b;
        t = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if ((i + j >= K) && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1)
                    t += (1 << (i + j));
        case (m)
            1:       return t;
            2:       return t + ((K > 0) ? (1 << (K - 1)) : 0);
            default: return e;
        endcase
    endfunction

    task automatic model_clear();
        m_wce = '0;
        m_cnt = '0;
        m_sum = '0;
    endtask

    // Scoreboard and statistics model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
            chk("wce", 64'(wce), 64'(m_wce));
            chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
            chk("err_sum", 64'(err_sum), 64'(m_sum));
            if (out_valid && out_ready) begin
                n_vec++;
                assert (q_p.size() != 0) else begin
                    n_err++;
                    $error("FAIL stale_beat: observed out_p %0d expected no output", out_p);
                end
                if (q_p.size() != 0) begin
                    logic [PW-1:0] ep, ed;
                    longint s;
                    ep = q_p.pop_front();
                    ed = q_d.pop_front();
                    chk("out_p", 64'(out_p), 64'(ep));
                    if (!err_clr) begin
                        if (ed > m_wce) m_wce = ed;
                        if (m_cnt != '1) m_cnt = m_cnt + 1;
                        s = longint'(m_sum) + longint'(ed);
                        m_sum = (s > 64'hFF_FFFF_FFFF) ? '1 : SW'(s);
                    end
                end
            end
            if (err_clr) model_clear();
            if (in_valid && in_ready) begin
                int p, e;
                p = ref_p(int'(in_a), int'(in_b), int'(in_mode));
                e = int'(in_a) * int'(in_b);
                q_p.push_back(PW'(p));
                q_d.push_back(PW'((e > p) ? e - p : p - e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int m, input int exp, input string tag);
        int n;
        in_a = W'(a); in_b = W'(b); in_mode = 2'(m); in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin cyc(); n++; end
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk(tag, 64'(out_p), 64'(exp));
        cyc();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q_p.delete();
        q_d.delete();
        model_clear();
    endtask

    initial begin
        int i, cy, n;
        logic acc;
        logic [PW-1:0] held;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_a = '0; in_b = '0; in_mode = '0; held = '0;
        model_clear();
        #2 do_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_wce", 64'(wce), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);
        chk("rst_sum", 64'(err_sum), 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Exact mode, latency of two cycles
        in_a = 8'd255; in_b = 8'd255; in_mode = 2'b00; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("t1_lat1", {63'd0, out_valid}, 64'd0);
        cyc();
        chk("t1_lat2", {63'd0, out_valid}, 64'd1);
        chk("t1_p", 64'(out_p), 64'd65025);
        cyc();
        chk("t1_wce", 64'(wce), 64'd0);
        chk("t1_cnt", 64'(err_cnt), 64'd1);

        // Truncation and bias on the all-ones corner
        send(255, 255, 1, 64976, "t2_trunc");
        chk("t2_wce_a", 64'(wce), 64'd49);
        send(255, 255, 2, 64984, "t2_bias");
        chk("t2_wce_b", 64'(wce), 64'd49);
        chk("t2_sum", 64'(err_sum), 64'd90);
        pulse_clr();
        chk("clr_cnt", 64'(err_cnt), 64'd0);

        // Small operands
        send(1, 1, 1, 0, "t3_1x1");
        send(0, 0, 2, 8, "t3_0x0");
        chk("t3_wce", 64'(wce), 64'd8);
        chk("t3_sum_a", 64'(err_sum), 64'd9);
        send(16, 16, 0, 256, "t3_16x16_exact");
        send(16, 16, 1, 256, "t3_16x16_trunc");
        chk("t3_cnt", 64'(err_cnt), 64'd4);
        chk("t3_sum_b", 64'(err_sum), 64'd9);
        pulse_clr();

        // Back-to-back stream with a three-cycle output stall
        i = 0; cy = 0; acc = 1'b1;
        while (i < 10 && cy < 60) begin
            if (acc) begin
                in_a = W'($urandom_range(0, 255));
                in_b = W'($urandom_range(0, 255));
                in_mode = 2'($urandom_range(0, 3));
            end
            in_valid = 1'b1;
            out_ready = !(cy >= 4 && cy <= 6);
            #1;
            if (cy >= 4 && cy <= 6) begin
                chk("t4_stall_rdy", {63'd0, in_ready}, 64'd0);
                if (cy == 4) held = out_p;
                else chk("t4_hold", 64'(out_p), 64'(held));
            end
            acc = in_ready;
            cyc();
            cy++;
            if (acc) i++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q_p.size() != 0 && n < 20) begin cyc(); n++; end
        chk("t4_drain", 64'(q_p.size()), 64'd0);
        chk("t4_cnt", 64'(err_cnt), 64'd10);

        // Clear coinciding with an output handshake
        pulse_clr();
        send(255, 255, 1, 64976, "t5_pre");
        chk("t5_pre_wce", 64'(wce), 64'd49);
        in_a = 8'd1; in_b = 8'd1; in_mode = 2'b01; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin cyc(); n++; end
        chk("t5_valid", {63'd0, out_valid}, 64'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t5_wce", 64'(wce), 64'd0);
        chk("t5_cnt", 64'(err_cnt), 64'd0);
        chk("t5_sum", 64'(err_sum), 64'd0);
        chk("t5_delivered", 64'(q_p.size()), 64'd0);

        // Reset with two beats in flight
        send(255, 255, 2, 64984, "t6_pre");
        in_mode = 2'b00; in_valid = 1'b1;
        in_a = 8'd3; in_b = 8'd5; cyc();
        in_a = 8'd7; in_b = 8'd9; cyc();
        in_valid = 1'b0;
        do_reset();
        #1;
        chk("t6_ov_now", {63'd0, out_valid}, 64'd0);
        chk("t6_wce_now", 64'(wce), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t6_no_stale", {63'd0, out_valid}, 64'd0);
        end
        chk("t6_cnt", 64'(err_cnt), 64'd0);
        chk("t6_sum", 64'(err_sum), 64'd0);

        // Randomized traffic with random backpressure and occasional clears
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = W'($urandom_range(0, 255));
            in_b      = W'($urandom_range(0, 255));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 31) == 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        n = 0;
        while (q_p.size() != 0 && n < 20) begin cyc(); n++; end
        chk("rand_drain", 64'(q_p.size()), 64'd0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
